// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - Button sampler sequencer feeding a FWFT FIFO of left/right move commands.
module move_scheduler #(
   parameter int TICK_W     = 8,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  run_i,
   input  logic [TICK_W-1:0]     tick_div_i,
   output logic                  samp_en_o,
   input  logic                  left_p_i,
   input  logic                  right_p_i,
   output logic                  mv_valid_o,
   output logic                  mv_dir_o,
   input  logic                  mv_ready_i,
   output logic [DEPTH_LOG2:0]   fifo_cnt_o,
   output logic                  overflow_o,
   input  logic                  clr_ovf_i,
   output logic                  conflict_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   DEPTH_C  = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
   localparam logic [TICK_W-1:0]     TICK_ONE = TICK_W'(1);

   typedef enum logic [1:0] {IDLE, SAMPLE, CAPTURE} state_e;

   state_e                 state_q, state_d;
   logic [TICK_W-1:0]      presc_q, presc_d;
   logic                   samp_en_q, samp_en_d;
   logic                   conflict_q, conflict_d;
   logic                   overflow_q, overflow_d;
   logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]    cnt_q, cnt_d;
   logic [DEPTH-1:0]       mem_q, mem_d;
   logic                   pop, push_req, push_ok;

   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      overflow_d = overflow_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      mem_d      = mem_q;

      pop        = (cnt_q != '0) && mv_ready_i;
      push_req   = (state_q == CAPTURE) && (left_p_i ^ right_p_i);
      // A full FIFO still takes a push when the head leaves in the same cycle.
      push_ok    = push_req && ((cnt_q < DEPTH_C) || pop);
      conflict_d = (state_q == CAPTURE) && left_p_i && right_p_i;

      case (state_q)
         IDLE: begin
            if (!run_i) begin
               presc_d = '0;
            end else if (presc_q == tick_div_i) begin
               presc_d = '0;
               state_d = SAMPLE;
            end else begin
               presc_d = presc_q + TICK_ONE;
            end
         end
         SAMPLE:  state_d = CAPTURE;
         CAPTURE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      samp_en_d = (state_d == SAMPLE);

      if (push_ok) begin
         mem_d[wr_ptr_q] = right_p_i;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push_ok && !pop) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (!push_ok && pop) begin
         cnt_d = cnt_q - CNT_ONE;
      end

      if (push_req && !push_ok) begin
         overflow_d = 1'b1;
      end else if (clr_ovf_i) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         presc_q    <= '0;
         samp_en_q  <= 1'b0;
         conflict_q <= 1'b0;
         overflow_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         mem_q      <= '0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         samp_en_q  <= samp_en_d;
         conflict_q <= conflict_d;
         overflow_q <= overflow_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         mem_q      <= mem_d;
      end
   end

   assign samp_en_o  = samp_en_q;
   assign conflict_o = conflict_q;
   assign overflow_o = overflow_q;
   assign fifo_cnt_o = cnt_q;
   assign mv_valid_o = (cnt_q != '0);
   assign mv_dir_o   = mem_q[rd_ptr_q];

endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
Sequences the debounced button sampler and turns its left/right pulses into a queued stream of move commands for the game logic. It generates the sampler's enable strobe at a programmable tick rate and captures the sampler result one cycle later. Simultaneous left+right presses are resolved as a conflict. Moves are buffered in a small first-word-fall-through FIFO and handed over with a valid/ready handshake.

Parameters:
TICK_W, 8, width of tick divider input and prescaler counter
DEPTH_LOG2, 2, log2 of move FIFO depth (default 4 entries)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
run_i  input  1  enable sampling; 0 = prescaler held at 0, no new strobes
tick_div_i  input  TICK_W  idle cycles between samples (sample period = tick_div_i + 3)
samp_en_o  output  1  enable strobe to the button sampler, one cycle wide
left_p_i  input  1  sampler left pulse, valid in cycle after samp_en_o
right_p_i  input  1  sampler right pulse, valid in cycle after samp_en_o
mv_valid_o  output  1  FIFO head valid
mv_dir_o  output  1  head move: 0 = left, 1 = right
mv_ready_i  input  1  consumer accepts head when mv_valid_o & mv_ready_i
fifo_cnt_o  output  DEPTH_LOG2+1  current FIFO occupancy
overflow_o  output  1  sticky: a move was dropped because the FIFO was full
clr_ovf_i  input  1  synchronous clear of overflow_o
conflict_o  output  1  one-cycle pulse: left and right captured together

Behaviour:
- Reset (rst_ni=0, async): FSM=IDLE, prescaler=0, FIFO empty (pointers 0), all outputs 0.
- FSM states: IDLE, SAMPLE, CAPTURE.
  - IDLE: if run_i=0, prescaler is forced to 0. Else if prescaler==tick_div_i, clear prescaler and go to SAMPLE. Else prescaler+1.
  - SAMPLE: samp_en_o=1 (registered, high only in this state); go to CAPTURE unconditionally.
  - CAPTURE: sample left_p_i/right_p_i; go to IDLE unconditionally.
- Dropping run_i mid-sequence does not abort SAMPLE/CAPTURE. The capture still completes.
- Strobe period with constant run_i: tick_div_i+3 cycles. tick_div_i=0 gives period 3.
- tick_div_i is compared live. If it changes below the current prescaler value, the prescaler counts on and wraps at 2^TICK_W before matching.
- CAPTURE decision:
  - left only -> push 0
  - right only -> push 1
  - both -> no push, conflict_o=1 in the next cycle
  - neither -> nothing
- FIFO: depth 2^DEPTH_LOG2, 1-bit entries, first-word fall-through.
  - mv_valid_o = (count!=0); mv_dir_o = head entry.
  - Pop occurs on mv_valid_o & mv_ready_i.
  - Push is accepted if count<depth, or if a pop occurs in the same cycle (count unchanged, pointers both advance).
  - Push while full with no pop: entry dropped, overflow_o set next cycle.
  - Pointers wrap modulo depth. count saturates logically at depth and is never incremented beyond it.
  - mv_ready_i while empty has no effect; count never underflows.
- overflow_o: set by a dropped push, cleared by clr_ovf_i. If both happen in the same cycle, set wins.
- Pushed data becomes visible at mv_valid_o/fifo_cnt_o one cycle after CAPTURE.
- mv_dir_o holds its value while mv_valid_o=1 and mv_ready_i=0.

Test Plan:
- Reset/idle: rst_ni low for 2 cycles mid-SAMPLE, then release with run_i=0 for 20 cycles -> samp_en_o never asserted, all outputs 0, fifo_cnt_o=0.
- Strobe period: run_i=1, tick_div_i=5 -> samp_en_o high exactly 1 cycle every 8 cycles. With tick_div_i=0 -> every 3 cycles.
- Single moves: left_p_i=1 in capture cycle, then right_p_i=1 on the next capture, mv_ready_i=0 -> fifo_cnt_o=2. Then mv_ready_i=1 -> mv_dir_o reads 0, then 1, then mv_valid_o=0.
- Conflict: left_p_i=right_p_i=1 in capture -> conflict_o 1-cycle pulse, fifo_cnt_o unchanged.
- Overflow: mv_ready_i=0, 5 consecutive right captures -> fifo_cnt_o=4, overflow_o=1 after 5th. Then clr_ovf_i pulse -> overflow_o=0. Drain yields 4 entries of 1.
- Full push+pop: FIFO full, mv_ready_i=1 in the cycle of a left push -> fifo_cnt_o stays 4, overflow_o stays 0, the left entry is the last drained.
